// File: rtl/morse_emitter_if.sv
// Bus between the register-file top level and the Morse key emitter.
interface morse_emitter_if;
  logic        ctrl_start;
  logic [31:0] data_r29;
  logic        morse_out;
  logic        busy;
  logic        done;
  logic [31:0] status_out;

  modport master (
    output ctrl_start, data_r29,
    input  morse_out, busy, done, status_out
  );

  modport slave (
    input  ctrl_start, data_r29,
    output morse_out, busy, done, status_out
  );
endinterface

// File: rtl/morse_emitter.sv
// Morse key emitter: serialises the symbol word held in r29 into a timed
// on/off key signal and reports overruns through status_out.
// Optional feature macro: MORSE_QUEUE_EN (one-entry holding register for a
// start that arrives while a symbol is still being emitted).
module morse_emitter #(
  parameter int unsigned UNIT_CYCLES = 1000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic            clock,
  input  logic            ctrl_reset,
  morse_emitter_if.slave  bus
);

  localparam int unsigned LEN_W = 3;
  localparam int unsigned PAT_W = 6;
  localparam int unsigned MAX_L = 6;

  localparam logic [CNT_W-1:0] LIM_1U = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_3U = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_7U = CNT_W'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               morse_q, morse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;

`ifdef MORSE_QUEUE_EN
  logic               qv_q, qv_d;
  logic [LEN_W-1:0]   qlen_q, qlen_d;
  logic [PAT_W-1:0]   qpat_q, qpat_d;
`endif

  logic [LEN_W-1:0]   in_len;
  logic [PAT_W-1:0]   in_pat;
  logic               launch;
  logic [LEN_W-1:0]   l_len;
  logic [PAT_W-1:0]   l_pat;
  logic [CNT_W-1:0]   on_lim;
  logic [LEN_W-1:0]   k_next;
  logic               unused_data;

  // Bits above the symbol field carry nothing for this block.
  assign unused_data = ^bus.data_r29[31:9];

  // Length field clipped to the six elements the pattern can hold.
  assign in_len = (bus.data_r29[2:0] > LEN_W'(MAX_L)) ? LEN_W'(MAX_L) : bus.data_r29[2:0];
  assign in_pat = bus.data_r29[8:3];
  assign on_lim = pat_q[k_q] ? LIM_3U : LIM_1U;
  assign k_next = LEN_W'(k_q + LEN_W'(1));

  // Next-state, counter, symbol latch and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    k_d     = k_q;
    len_d   = len_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    launch  = 1'b0;
    l_len   = in_len;
    l_pat   = in_pat;
`ifdef MORSE_QUEUE_EN
    qv_d    = qv_q;
    qlen_d  = qlen_q;
    qpat_d  = qpat_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef MORSE_QUEUE_EN
        if (qv_q) begin
          launch = 1'b1;
          l_len  = qlen_q;
          l_pat  = qpat_q;
          qv_d   = 1'b0;
        end else if (bus.ctrl_start) begin
          launch = 1'b1;
        end
`else
        if (bus.ctrl_start) begin
          launch = 1'b1;
        end
`endif
      end
      S_ON: begin
        if (cnt_q == on_lim) begin
          cnt_d   = '0;
          state_d = (k_next < len_q) ? S_GAP : S_CHAR_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == LIM_1U) begin
          cnt_d   = '0;
          k_d     = k_next;
          state_d = S_ON;
        end
      end
      S_CHAR_GAP: begin
        if (cnt_q == LIM_3U) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_WORD_GAP: begin
        if (cnt_q == LIM_7U) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      len_d   = l_len;
      pat_d   = l_pat;
      k_d     = '0;
      cnt_d   = '0;
      state_d = (l_len != '0) ? S_ON : S_WORD_GAP;
    end

    // A start seen while busy is either parked in the holding slot or reported.
    if (bus.ctrl_start && busy_q) begin
`ifdef MORSE_QUEUE_EN
      if (!qv_q || (state_q == S_IDLE)) begin
        qv_d   = 1'b1;
        qlen_d = in_len;
        qpat_d = in_pat;
      end else begin
        ovr_d = 1'b1;
      end
`else
      ovr_d = 1'b1;
`endif
    end

    morse_d = (state_d == S_ON);
`ifdef MORSE_QUEUE_EN
    busy_d  = (state_d != S_IDLE) || qv_d;
`else
    busy_d  = (state_d != S_IDLE);
`endif
  end

  // State and output registers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      morse_q <= morse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef MORSE_QUEUE_EN
  // Holding register for one pending symbol.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      qv_q   <= 1'b0;
      qlen_q <= '0;
      qpat_q <= '0;
    end else begin
      qv_q   <= qv_d;
      qlen_q <= qlen_d;
      qpat_q <= qpat_d;
    end
  end
`endif

  assign bus.morse_out  = morse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.status_out = {31'd0, ovr_q};

endmodule

// File: tb/tb_morse_emitter.sv
// Self-checking bench for morse_emitter with a unit of two clock cycles.
module tb_morse_emitter;

  localparam int unsigned U = 2;

  logic clock = 1'b0;
  logic ctrl_reset;

  morse_emitter_if bus ();

  morse_emitter #(.UNIT_CYCLES(U), .CNT_W(24)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit exp_wave[$];

  typedef struct {
    logic [31:0] data;
    int          busy_cyc;
    int          on_cyc;
    bit          b2b;
    string       name;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference key waveform built from the Morse timing rules.
  task automatic build_wave(input logic [31:0] d);
    int l;
    logic [5:0] p;
    exp_wave.delete();
    l = int'(d[2:0]);
    if (l > 6) l = 6;
    p = d[8:3];
    if (l == 0) begin
      for (int i = 0; i < 7 * U; i++) exp_wave.push_back(1'b0);
    end else begin
      for (int k = 0; k < l; k++) begin
        for (int i = 0; i < (p[k] ? 3 : 1) * U; i++) exp_wave.push_back(1'b1);
        for (int i = 0; i < ((k < l - 1) ? 1 : 3) * U; i++) exp_wave.push_back(1'b0);
      end
    end
  endtask

  task automatic issue_start(input logic [31:0] d);
    bus.ctrl_start = 1'b1;
    bus.data_r29   = d;
    @(negedge clock);
    bus.ctrl_start = 1'b0;
    bus.data_r29   = $urandom();
  endtask

  // Checks the emitted symbol cycle by cycle, ending on the done cycle.
  task automatic check_wave(input string name, input bit done_busy,
                            output int busy_cnt, output int on_cnt);
    busy_cnt = 0;
    on_cnt   = 0;
    for (int i = 0; i < exp_wave.size(); i++) begin
      chk({name, " key/busy/done"}, 32'({bus.morse_out, bus.busy, bus.done}),
          32'({exp_wave[i], 1'b1, 1'b0}));
      chk({name, " status"}, bus.status_out, 32'd0);
      busy_cnt += int'(bus.busy);
      on_cnt   += int'(bus.morse_out);
      bus.data_r29 = $urandom();
      @(negedge clock);
    end
    chk({name, " done cycle"}, 32'({bus.morse_out, bus.busy, bus.done}),
        32'({1'b0, done_busy, 1'b1}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bc, oc;
    logic [31:0] d;

    vt[0] = '{32'h0000_0001, 8,  2,  1'b0, "E"};
    vt[1] = '{32'h0000_0012, 16, 8,  1'b0, "A"};
    vt[2] = '{32'h0000_0000, 14, 0,  1'b0, "space"};
    // Bit 8 of 0xFF is clear, so the sixth element is a dot.
    vt[3] = '{32'h0000_00FF, 48, 32, 1'b1, "clip_ff"};
    vt[4] = '{32'h0000_01FF, 52, 36, 1'b1, "six_dash"};
    vt[5] = '{32'hFFFF_FE01, 8,  2,  1'b1, "E_hi_bits"};

    ctrl_reset     = 1'b1;
    bus.ctrl_start = 1'b0;
    bus.data_r29   = '0;
    repeat (2) @(negedge clock);
    chk("reset key", 32'(bus.morse_out), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset status", bus.status_out, 32'd0);
    ctrl_reset = 1'b0;
    @(negedge clock);

    // Directed table, some vectors started on the previous done cycle.
    for (int i = 0; i < 6; i++) begin
      if (!vt[i].b2b) @(negedge clock);
      build_wave(vt[i].data);
      issue_start(vt[i].data);
      check_wave(vt[i].name, 1'b0, bc, oc);
      chk({vt[i].name, " busy cycles"}, 32'(bc), 32'(vt[i].busy_cyc));
      chk({vt[i].name, " on cycles"}, 32'(oc), 32'(vt[i].on_cyc));
    end

    // Random symbols against the reference model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clock);
      d = $urandom();
      build_wave(d);
      issue_start(d);
      check_wave("rand", 1'b0, bc, oc);
      chk("rand busy cycles", 32'(bc), 32'(exp_wave.size()));
    end

    // Second start while 'E' is still being emitted.
    @(negedge clock);
    build_wave(32'h01);
    issue_start(32'h01);
    for (int i = 0; i < exp_wave.size(); i++) begin
      chk("ovr key/busy/done", 32'({bus.morse_out, bus.busy, bus.done}),
          32'({exp_wave[i], 1'b1, 1'b0}));
`ifdef MORSE_QUEUE_EN
      chk("ovr status", bus.status_out, 32'd0);
`else
      chk("ovr status", bus.status_out, (i == 3) ? 32'd1 : 32'd0);
`endif
      if (i == 2) begin
        bus.ctrl_start = 1'b1;
        bus.data_r29   = 32'h12;
      end
      if (i == 3) begin
        bus.ctrl_start = 1'b0;
        bus.data_r29   = $urandom();
      end
      @(negedge clock);
    end
`ifdef MORSE_QUEUE_EN
    chk("ovr done cycle", 32'({bus.morse_out, bus.busy, bus.done}), 32'({1'b0, 1'b1, 1'b1}));
    @(negedge clock);
    build_wave(32'h12);
    check_wave("queued A", 1'b0, bc, oc);
    chk("queued A busy cycles", 32'(bc), 32'd16);
`else
    chk("ovr done cycle", 32'({bus.morse_out, bus.busy, bus.done}), 32'({1'b0, 1'b0, 1'b1}));
    @(negedge clock);
    chk("ovr no follow-on", 32'({bus.morse_out, bus.busy, bus.done}), 32'd0);
`endif

    // Asynchronous reset in the middle of a dash.
    @(negedge clock);
    issue_start(32'h09);
    repeat (2) @(negedge clock);
    chk("pre-reset key", 32'(bus.morse_out), 32'd1);
    #2 ctrl_reset = 1'b1;
    #1;
    chk("async reset key/busy/done", 32'({bus.morse_out, bus.busy, bus.done}), 32'd0);
    chk("async reset status", bus.status_out, 32'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post-reset idle", 32'({bus.morse_out, bus.busy, bus.done}), 32'd0);
    end

    // Emitter recovers normally after the abort.
    build_wave(32'h01);
    issue_start(32'h01);
    check_wave("E after reset", 1'b0, bc, oc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
